// File: rtl/ahblite_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_slave_mux
// Purpose  : AHB-Lite data-phase response mux with built-in ERROR default slave
// Revision : 1.0
// ============================================================================
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [4:0] c_PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_sel;
  logic [4:0]  w_masked;
  logic [4:0]  w_prio;
  logic        w_dflt;
  logic        w_err_start;
  logic        w_dflt_owned;
  logic        w_dflt_ready;
  logic        w_dflt_resp;
  logic [31:0] w_rdata [5];
  logic [4:0]  w_ready;
  logic [4:0]  w_resp;
  logic        w_unused;

  assign w_unused = HTRANS[0];

  // Lowest-index enabled select wins; x & -x isolates the lowest set bit.
  assign w_masked    = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & c_PORT_EN;
  assign w_prio      = w_masked & (~w_masked + 5'd1);
  assign w_dflt      = ~|w_masked;
  assign w_err_start = HREADY & w_dflt & HTRANS[1];

  assign w_rdata[0] = P0_HRDATA;
  assign w_rdata[1] = P1_HRDATA;
  assign w_rdata[2] = P2_HRDATA;
  assign w_rdata[3] = P3_HRDATA;
  assign w_rdata[4] = P4_HRDATA;
  assign w_ready    = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign w_resp     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sel <= 6'd0;
    end else if (HREADY) begin
      r_sel <= {w_dflt, w_prio};
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dflt_ready = 1'b1;
    w_dflt_resp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_err_start) w_state_nxt = S_ERR1;
      end
      S_ERR1: begin
        w_dflt_ready = 1'b0;
        w_dflt_resp  = 1'b1;
        w_state_nxt  = S_ERR2;
      end
      S_ERR2: begin
        w_dflt_resp = 1'b1;
        w_state_nxt = w_err_start ? S_ERR1 : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An empty select (after reset) behaves exactly like the default slave.
  assign w_dflt_owned = r_sel[5] | (r_sel[4:0] == 5'd0);

  always_comb begin
    HRDATA    = 32'd0;
    HREADYOUT = w_dflt_ready;
    HRESP     = w_dflt_resp;
    if (!w_dflt_owned) begin
      for (int i = 4; i >= 0; i--) begin
        if (r_sel[i]) begin
          HRDATA    = w_rdata[i];
          HREADYOUT = w_ready[i];
          HRESP     = w_resp[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahblite_slave_mux.sv
`default_nettype none
// Self-checking bench for ahblite_slave_mux: vector table plus hand-written
// error/reset sequences, all checked through an expectation queue.
module tb_ahblite_slave_mux;

  localparam logic [1:0] c_NS = 2'b10;
  localparam logic [1:0] c_ID = 2'b00;

  logic        clk;
  logic        rst;
  logic [1:0]  htrans;
  logic [4:0]  hsel;
  logic [4:0]  prdy;
  logic [4:0]  presp;
  logic [31:0] base;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  hs;
    logic [4:0]  rdy;
    logic [4:0]  rsp;
    logic [31:0] d;
    logic [31:0] er;
    logic        ey;
    logic        ez;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        ry;
    logic        rz;
  } exp_t;

  vec_t tbl [14];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;

  ahblite_slave_mux dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .HREADY      (hready),
    .HTRANS      (htrans),
    .P0_HSEL     (hsel[0]),
    .P1_HSEL     (hsel[1]),
    .P2_HSEL     (hsel[2]),
    .P3_HSEL     (hsel[3]),
    .P4_HSEL     (hsel[4]),
    .P0_HRDATA   (base + 32'd0),
    .P1_HRDATA   (base + 32'd1),
    .P2_HRDATA   (base + 32'd2),
    .P3_HRDATA   (base + 32'd3),
    .P4_HRDATA   (base + 32'd4),
    .P0_HREADYOUT(prdy[0]),
    .P1_HREADYOUT(prdy[1]),
    .P2_HREADYOUT(prdy[2]),
    .P3_HREADYOUT(prdy[3]),
    .P4_HREADYOUT(prdy[4]),
    .P0_HRESP    (presp[0]),
    .P1_HRESP    (presp[1]),
    .P2_HRESP    (presp[2]),
    .P3_HRESP    (presp[3]),
    .P4_HRESP    (presp[4]),
    .HRDATA      (hrdata),
    .HREADYOUT   (hready),
    .HRESP       (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] er, input logic ey, input logic ez);
    n_cmp++;
    if (hrdata !== er || hready !== ey || hresp !== ez) begin
      n_err++;
      $display("FAIL %s: got HRDATA=%08h HREADYOUT=%b HRESP=%b, want HRDATA=%08h HREADYOUT=%b HRESP=%b",
               nm, hrdata, hready, hresp, er, ey, ez);
    end
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.nm, e.rd, e.ry, e.rz);
    end
  end

  task automatic step(input string nm, input logic r, input logic [1:0] t, input logic [4:0] hs,
                      input logic [4:0] rdy, input logic [4:0] rsp, input logic [31:0] d,
                      input logic [31:0] er, input logic ey, input logic ez);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    htrans = t;
    hsel   = hs;
    prdy   = rdy;
    presp  = rsp;
    base   = d;
    e.nm = nm; e.rd = er; e.ry = ey; e.rz = ez;
    sb.push_back(e);
  endtask

  initial begin
    rst    = 1'b1;
    htrans = c_ID;
    hsel   = 5'd0;
    prdy   = 5'h1f;
    presp  = 5'd0;
    base   = 32'd0;

    //        trans  hsel    rdy     rsp     data           exp data       rdy   rsp
    tbl[0]  = '{c_ID, 5'h00, 5'h1f, 5'h00, 32'h00000100, 32'h00000000, 1'b1, 1'b0};
    tbl[1]  = '{c_NS, 5'h02, 5'h1f, 5'h00, 32'h00000200, 32'h00000000, 1'b1, 1'b0};
    tbl[2]  = '{c_ID, 5'h01, 5'h1d, 5'h00, 32'h12345677, 32'h12345678, 1'b0, 1'b0};
    tbl[3]  = '{c_NS, 5'h01, 5'h1d, 5'h00, 32'h12345677, 32'h12345678, 1'b0, 1'b0};
    tbl[4]  = '{c_NS, 5'h00, 5'h1f, 5'h00, 32'h12345677, 32'h12345678, 1'b1, 1'b0};
    tbl[5]  = '{c_NS, 5'h00, 5'h1f, 5'h00, 32'h00000300, 32'h00000000, 1'b0, 1'b1};
    tbl[6]  = '{c_ID, 5'h00, 5'h1f, 5'h00, 32'h00000300, 32'h00000000, 1'b1, 1'b1};
    tbl[7]  = '{c_NS, 5'h10, 5'h1f, 5'h00, 32'h00000400, 32'h00000000, 1'b1, 1'b0};
    tbl[8]  = '{c_NS, 5'h10, 5'h0f, 5'h10, 32'h00000500, 32'h00000000, 1'b0, 1'b1};
    tbl[9]  = '{c_NS, 5'h04, 5'h0f, 5'h10, 32'h00000500, 32'h00000000, 1'b1, 1'b1};
    tbl[10] = '{c_NS, 5'h08, 5'h1f, 5'h04, 32'h00000600, 32'h00000602, 1'b1, 1'b1};
    tbl[11] = '{c_NS, 5'h03, 5'h1f, 5'h00, 32'h00000700, 32'h00000703, 1'b1, 1'b0};
    tbl[12] = '{c_ID, 5'h00, 5'h1f, 5'h00, 32'h00000800, 32'h00000800, 1'b1, 1'b0};
    tbl[13] = '{c_ID, 5'h00, 5'h1f, 5'h00, 32'h00000900, 32'h00000000, 1'b1, 1'b0};

    // Reset held with random bus activity, then released with no transfer.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("reset%0d", i), 1'b1, 2'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom, 32'h0, 1'b1, 1'b0);
    end
    step("post_reset0", 1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'hdead0000, 32'h0, 1'b1, 1'b0);
    step("post_reset1", 1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'hdead0000, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), 1'b0, tbl[i].t, tbl[i].hs, tbl[i].rdy, tbl[i].rsp,
           tbl[i].d, tbl[i].er, tbl[i].ey, tbl[i].ez);
    end

    // Back-to-back unmapped transfers, reset asserted during the second ERR1.
    step("b2b_issue",  1'b0, c_NS, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b1, 1'b0);
    step("b2b_err1a",  1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b0, 1'b1);
    step("b2b_err2a",  1'b0, c_NS, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b1, 1'b1);
    step("b2b_err1b",  1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", 32'h0, 1'b1, 1'b0);
    step("rst_hold",   1'b1, c_NS, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b1, 1'b0);
    step("rst_rel",    1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h1000, 32'h0, 1'b1, 1'b0);

    // Full back-to-back error sequence ending in IDLE.
    step("seq_issue",  1'b0, c_NS, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b1, 1'b0);
    step("seq_err1a",  1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b0, 1'b1);
    step("seq_err2a",  1'b0, c_NS, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b1, 1'b1);
    step("seq_err1b",  1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b0, 1'b1);
    step("seq_err2b",  1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b1, 1'b1);
    step("seq_idle",   1'b0, c_ID, 5'h00, 5'h1f, 5'h00, 32'h2000, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
